// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// parity-mode selectors and tuser bit positions.
package uart_pkg;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_START  = 5'b00010,
        ST_DATA   = 5'b00100,
        ST_PARITY = 5'b01000,
        ST_STOP   = 5'b10000
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int TUSER_FRAME_ERR  = 0;
    localparam int TUSER_PARITY_ERR = 1;

endpackage

// File: rtl/uart_rx_frame_sync.sv
// Two-flop synchronizer for the asynchronous Rx pin; resets to the idle-high
// line level so no false start edge is seen after reset.
module uart_rx_frame_sync (
    input  logic Clk,
    input  logic Rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver with oversampled bit timing and an AXI-Stream output register.
// Define UART_RX_FRAME_MAJORITY_EN for 2-of-3 voting around each sample point.
//
//  state     | meaning
//  ST_IDLE   | line idle, waiting for a falling edge on rx_s
//  ST_START  | qualifying the start bit at its sample point
//  ST_DATA   | shifting in data bits, LSB first
//  ST_PARITY | checking the parity bit against the data
//  ST_STOP   | sampling stop bit(s); frame completes at the last sample
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Baud_tick,
    input  logic                 Rx,
    output logic [DATA_BITS-1:0] M_axis_tdata,
    output logic [1:0]           M_axis_tuser,
    output logic                 M_axis_tvalid,
    input  logic                 M_axis_tready,
    output logic                 Overrun,
    output logic                 Busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    logic rx_s;
    logic rx_d_q, rx_d_d;
    logic bit_val;

    state_t                 state_q, state_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic [3:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_err_q, par_err_d;
    logic                   frame_err_q, frame_err_d;
    logic [DATA_BITS-1:0]   tdata_q, tdata_d;
    logic [1:0]             tuser_q, tuser_d;
    logic                   tvalid_q, tvalid_d;
    logic                   overrun_q, overrun_d;
    logic                   sample_en, bit_end, complete;

    uart_rx_frame_sync u_sync (
        .Clk (Clk),
        .Rst (Rst),
        .d   (Rx),
        .q   (rx_s)
    );

`ifdef UART_RX_FRAME_MAJORITY_EN
    // Decision taken one tick late so the third vote is the live rx_s.
    localparam logic [TW-1:0] TICK_SAMPLE = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] TICK_VOTE_A = TW'(OVERSAMPLE / 2 - 2);
    localparam logic [TW-1:0] TICK_VOTE_B = TW'(OVERSAMPLE / 2 - 1);

    logic [1:0] vote_q, vote_d;

    always_comb begin
        vote_d = vote_q;
        if (Baud_tick && tick_q == TICK_VOTE_A) vote_d[0] = rx_s;
        if (Baud_tick && tick_q == TICK_VOTE_B) vote_d[1] = rx_s;
    end

    always_ff @(posedge Clk) begin
        if (Rst) vote_q <= 2'b11;
        else     vote_q <= vote_d;
    end

    assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);
`else
    localparam logic [TW-1:0] TICK_SAMPLE = TW'(OVERSAMPLE / 2 - 1);

    assign bit_val = rx_s;
`endif

    assign sample_en = Baud_tick && (tick_q == TICK_SAMPLE);
    assign bit_end   = Baud_tick && (tick_q == TICK_LAST);

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        par_err_d   = par_err_q;
        frame_err_d = frame_err_q;
        rx_d_d      = rx_s;
        complete    = 1'b0;

        if (Baud_tick) tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + TW'(1);

        case (state_q)
            ST_IDLE: begin
                if (rx_d_q && !rx_s) begin
                    state_d     = ST_START;
                    tick_d      = '0;
                    bit_d       = '0;
                    par_err_d   = 1'b0;
                    frame_err_d = 1'b0;
                end
            end
            ST_START: begin
                if (sample_en && bit_val) state_d = ST_IDLE;
                else if (bit_end)         state_d = ST_DATA;
            end
            ST_DATA: begin
                if (sample_en) shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                if (bit_end) begin
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (sample_en) begin
                    par_err_d = (PARITY == PAR_EVEN) ? (^{shift_q, bit_val})
                                                     : ~(^{shift_q, bit_val});
                end
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                // Leave at the last stop sample so a back-to-back start edge is seen.
                if (sample_en) begin
                    if (!bit_val) frame_err_d = 1'b1;
                    if (bit_q == STOP_LAST) begin
                        complete = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end else if (bit_end) begin
                    bit_d = bit_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tdata_d   = tdata_q;
        tuser_d   = tuser_q;
        tvalid_d  = tvalid_q;
        overrun_d = 1'b0;

        if (tvalid_q && M_axis_tready) tvalid_d = 1'b0;

        if (complete) begin
            if (!tvalid_q || M_axis_tready) begin
                tdata_d                   = shift_q;
                tuser_d[TUSER_PARITY_ERR] = par_err_q;
                tuser_d[TUSER_FRAME_ERR]  = frame_err_q | ~bit_val;
                tvalid_d                  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            rx_d_q      <= 1'b1;
            state_q     <= ST_IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            tdata_q     <= '0;
            tuser_q     <= '0;
            tvalid_q    <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_d_q      <= rx_d_d;
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            par_err_q   <= par_err_d;
            frame_err_q <= frame_err_d;
            tdata_q     <= tdata_d;
            tuser_q     <= tuser_d;
            tvalid_q    <= tvalid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign M_axis_tdata  = tdata_q;
    assign M_axis_tuser  = tuser_q;
    assign M_axis_tvalid = tvalid_q;
    assign Overrun       = overrun_q;
    assign Busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: lane 0 uses defaults with Baud_tick tied
// high, lane 1 uses even parity with Baud_tick every 4th clock.
module tb_uart_rx_frame;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    logic       tick0 = 1'b1;
    logic       rx0 = 1'b1, tready0 = 1'b1;
    logic [7:0] tdata0;
    logic [1:0] tuser0;
    logic       tvalid0, overrun0, busy0;

    logic [1:0] tdiv = 2'd0;
    logic       tick1;
    logic       rx1 = 1'b1, tready1 = 1'b1;
    logic [7:0] tdata1;
    logic [1:0] tuser1;
    logic       tvalid1, overrun1, busy1;

    always @(posedge Clk) tdiv <= tdiv + 2'd1;
    assign tick1 = (tdiv == 2'd3);

    uart_rx_frame dut0 (
        .Clk(Clk), .Rst(Rst), .Baud_tick(tick0), .Rx(rx0),
        .M_axis_tdata(tdata0), .M_axis_tuser(tuser0), .M_axis_tvalid(tvalid0),
        .M_axis_tready(tready0), .Overrun(overrun0), .Busy(busy0)
    );

    uart_rx_frame #(.PARITY(2)) dut1 (
        .Clk(Clk), .Rst(Rst), .Baud_tick(tick1), .Rx(rx1),
        .M_axis_tdata(tdata1), .M_axis_tuser(tuser1), .M_axis_tvalid(tvalid1),
        .M_axis_tready(tready1), .Overrun(overrun1), .Busy(busy1)
    );

    int checks = 0;
    int errors = 0;
    int ovr0 = 0;
    int ovr1 = 0;
    logic [9:0] q0[$];
    logic [9:0] q1[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitors: pop on handshake, hold-check while stalled.
    always @(negedge Clk) begin
        if (!Rst) begin
            if (overrun0) ovr0++;
            if (overrun1) ovr1++;
            if (tvalid0) begin
                if (q0.size() == 0) check("lane0_unexpected_word", {22'd0, tuser0, tdata0}, 32'hFFFF_FFFF);
                else if (tready0)   check("lane0_word", {22'd0, tuser0, tdata0}, {22'd0, q0.pop_front()});
                else                check("lane0_hold", {22'd0, tuser0, tdata0}, {22'd0, q0[0]});
            end
            if (tvalid1) begin
                if (q1.size() == 0) check("lane1_unexpected_word", {22'd0, tuser1, tdata1}, 32'hFFFF_FFFF);
                else if (tready1)   check("lane1_word", {22'd0, tuser1, tdata1}, {22'd0, q1.pop_front()});
                else                check("lane1_hold", {22'd0, tuser1, tdata1}, {22'd0, q1[0]});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic set_rx(input int lane, input logic v);
        if (lane == 0) rx0 = v;
        else           rx1 = v;
    endtask

    function automatic logic busy_of(input int lane);
        return (lane == 0) ? busy0 : busy1;
    endfunction

    task automatic send_bit(input int lane, input logic v, input bit glitch);
        int nb;
        nb = (lane == 0) ? 16 : 64;
        set_rx(lane, v);
        if (glitch) begin
            step(8);
            set_rx(lane, ~v);
            step(1);
            set_rx(lane, v);
            step(nb - 9);
        end else begin
            step(nb);
        end
    endtask

    task automatic send_frame(input int lane, input logic [7:0] d, input logic par_flip,
                              input bit bad_stop, input bit glitch);
        int per;
        per = (lane == 0) ? 1 : 4;
        send_bit(lane, 1'b0, glitch);
        for (int i = 0; i < 8; i++) begin
            send_bit(lane, d[i], glitch);
            if (i == 3) check("busy_mid_frame", {31'd0, busy_of(lane)}, 32'd1);
        end
        if (lane == 1) send_bit(lane, (^d) ^ par_flip, glitch);
        if (bad_stop) begin
            set_rx(lane, 1'b0);
            step(10 * per);
            set_rx(lane, 1'b1);
            step(6 * per);
        end else begin
            send_bit(lane, 1'b1, glitch);
        end
        check("busy_after_stop", {31'd0, busy_of(lane)}, 32'd0);
    endtask

    initial begin
        int guard;
        Rst = 1'b1;
        step(4);
        check("rst_tvalid0", {31'd0, tvalid0}, 32'd0);
        check("rst_tdata0", {24'd0, tdata0}, 32'd0);
        check("rst_tuser0", {30'd0, tuser0}, 32'd0);
        check("rst_busy0", {31'd0, busy0}, 32'd0);
        check("rst_overrun0", {31'd0, overrun0}, 32'd0);
        check("rst_tvalid1", {31'd0, tvalid1}, 32'd0);
        check("rst_busy1", {31'd0, busy1}, 32'd0);
        Rst = 1'b0;
        step(3);

        // Default config, continuous tick
        q0.push_back({2'b00, 8'hA5});
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0);
        step(3);
        check("a5_single_valid", {31'd0, tvalid0}, 32'd0);

        // Even parity, tick every 4th clock
        q1.push_back({2'b10, 8'h3C});
        send_frame(1, 8'h3C, 1'b1, 1'b0, 1'b0);
        q1.push_back({2'b00, 8'h3C});
        send_frame(1, 8'h3C, 1'b0, 1'b0, 1'b0);
        q1.push_back({2'b00, 8'h07});
        send_frame(1, 8'h07, 1'b0, 1'b0, 1'b0);
        q1.push_back({2'b10, 8'h07});
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b0);
        step(10);

        // Framing error followed by a back-to-back frame
        q0.push_back({2'b01, 8'h55});
        q0.push_back({2'b00, 8'h12});
        send_frame(0, 8'h55, 1'b0, 1'b1, 1'b0);
        send_frame(0, 8'h12, 1'b0, 1'b0, 1'b0);
        step(10);

        // Short low glitch on idle line
        rx0 = 1'b0;
        step(3);
        rx0 = 1'b1;
        check("glitch_busy_high", {31'd0, busy0}, 32'd1);
        step(10);
        check("glitch_busy_low", {31'd0, busy0}, 32'd0);
        step(20);

        // Overrun: consumer stalled across two frames
        tready0 = 1'b0;
        q0.push_back({2'b00, 8'h11});
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(0, 8'h22, 1'b0, 1'b0, 1'b0);
        step(5);
        check("overrun_count", ovr0, 32'd1);
        check("held_tvalid", {31'd0, tvalid0}, 32'd1);
        check("held_tdata", {24'd0, tdata0}, 32'h11);
        tready0 = 1'b1;
        step(2);
        check("tvalid_after_accept", {31'd0, tvalid0}, 32'd0);
        check("queue0_after_accept", q0.size(), 32'd0);

        // Reset mid-data of 0xFF, then a clean 0x81
        send_bit(0, 1'b0, 1'b0);
        send_bit(0, 1'b1, 1'b0);
        send_bit(0, 1'b1, 1'b0);
        step(8);
        Rst = 1'b1;
        step(2);
        Rst = 1'b0;
        step(1);
        check("midreset_busy", {31'd0, busy0}, 32'd0);
        check("midreset_tvalid", {31'd0, tvalid0}, 32'd0);
        step(40);
        q0.push_back({2'b00, 8'h81});
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b0);
        step(10);

`ifdef UART_RX_FRAME_MAJORITY_EN
        // One-tick glitch at each bit's sample point is outvoted
        q0.push_back({2'b00, 8'h5A});
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
        step(10);
`endif

        guard = 0;
        while ((q0.size() != 0 || q1.size() != 0) && guard < 2000) begin
            step(1);
            guard++;
        end
        check("scoreboard_drained", q0.size() + q1.size(), 32'd0);
        check("final_overrun0", ovr0, 32'd1);
        check("final_overrun1", ovr1, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
